// File: rtl/axi_r_stream_tap_if.sv
// axi_r_stream_tap_if: pass-through R channel plus monitor-stream signals of axi_r_stream_tap.
interface axi_r_stream_tap_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 32,
  parameter int USER_WIDTH = 64
);
  logic                  ready;
  logic                  valid;
  logic                  in_progress;
  logic                  last;
  logic [DATA_WIDTH-1:0] data;
  logic [ID_WIDTH-1:0]   AXIM_rid;
  logic [DATA_WIDTH-1:0] AXIM_rdata;
  logic [1:0]            AXIM_rresp;
  logic                  AXIM_rlast;
  logic [USER_WIDTH-1:0] AXIM_ruser;
  logic                  AXIM_rvalid;
  logic                  AXIM_rready;
  logic [ID_WIDTH-1:0]   AXIS_rid;
  logic [DATA_WIDTH-1:0] AXIS_rdata;
  logic [1:0]            AXIS_rresp;
  logic                  AXIS_rlast;
  logic [USER_WIDTH-1:0] AXIS_ruser;
  logic                  AXIS_rvalid;
  logic                  AXIS_rready;
  modport master (
    input  ready, AXIM_rready, AXIS_rid, AXIS_rdata, AXIS_rresp, AXIS_rlast, AXIS_ruser, AXIS_rvalid,
    output valid, in_progress, last, data, AXIM_rid, AXIM_rdata, AXIM_rresp, AXIM_rlast, AXIM_ruser,
           AXIM_rvalid, AXIS_rready
  );
  modport slave (
    output ready, AXIM_rready, AXIS_rid, AXIS_rdata, AXIS_rresp, AXIS_rlast, AXIS_ruser, AXIS_rvalid,
    input  valid, in_progress, last, data, AXIM_rid, AXIM_rdata, AXIM_rresp, AXIM_rlast, AXIM_ruser,
           AXIM_rvalid, AXIS_rready
  );
endinterface

// File: rtl/axi_r_stream_tap.sv
// axi_r_stream_tap: transparent AXI R tap buffering beats into a FIFO and framing them as header/beats/trailer.
// Define AXI_R_TAP_USER_EN to also capture ruser and emit it as a beat between header and data.
module axi_r_stream_tap #(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = '0,
  parameter int                           FIFO_DEPTH        = 4,
  parameter int                           CNT_WIDTH         = 9
) (
  input logic                clk,
  input logic                reset,
  axi_r_stream_tap_if.master bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXW = ID_WIDTH > CNT_WIDTH ? ID_WIDTH : CNT_WIDTH;
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];
  localparam int TOP  = DATA_WIDTH - 1;
  localparam int RSP  = DATA_WIDTH - STREAM_TYPE_WIDTH - 1;

  if (DATA_WIDTH < STREAM_TYPE_WIDTH + 2 + MAXW || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || USER_WIDTH < 1) begin : g_bad_params
    $error("axi_r_stream_tap: illegal parameter combination");
  end

  typedef struct packed {
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
`ifdef AXI_R_TAP_USER_EN
    logic [USER_WIDTH-1:0] ruser;
`endif
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
`ifdef AXI_R_TAP_USER_EN
    USR,
`endif
    BEAT,
    TRL
  } state_t;

  state_t                state_q, state_d;
  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  entry_t                in_e, head;
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  beats_q, beats_d;
  logic [1:0]            worst_q, worst_d;
  logic                  full, empty, push, pop;
  logic                  valid_o, last_o;
  logic [DATA_WIDTH-1:0] data_o;

  assign full  = cnt_q == DEPTH_L;
  assign empty = cnt_q == '0;
  assign head  = mem_q[rd_q];

  // Reset clears cnt_q asynchronously, so the gating below is already transparent while reset is high.
  assign bus.AXIM_rvalid = bus.AXIS_rvalid && (reset || !full);
  assign bus.AXIS_rready = bus.AXIM_rready && (reset || !full);
  assign bus.AXIM_rid    = bus.AXIS_rid;
  assign bus.AXIM_rdata  = bus.AXIS_rdata;
  assign bus.AXIM_rresp  = bus.AXIS_rresp;
  assign bus.AXIM_rlast  = bus.AXIS_rlast;
  assign bus.AXIM_ruser  = bus.AXIS_ruser;
  assign push = !reset && bus.AXIS_rvalid && bus.AXIS_rready;

  assign bus.valid       = valid_o;
  assign bus.last        = last_o;
  assign bus.data        = data_o;
  assign bus.in_progress = state_q != IDLE;

  always_comb begin
    in_e.rid   = bus.AXIS_rid;
    in_e.rdata = bus.AXIS_rdata;
    in_e.rresp = bus.AXIS_rresp;
    in_e.rlast = bus.AXIS_rlast;
`ifdef AXI_R_TAP_USER_EN
    in_e.ruser = bus.AXIS_ruser;
`endif
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_e;
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    worst_d = worst_q;
    pop     = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    case (state_q)
      IDLE: begin
        beats_d = '0;
        worst_d = '0;
        state_d = empty ? IDLE : HDR;
      end
      HDR: begin
        valid_o = 1'b1;
        data_o[TOP -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
        data_o[ID_WIDTH-1:0] = head.rid;
`ifdef AXI_R_TAP_USER_EN
        state_d = bus.ready ? USR : HDR;
      end
      USR: begin
        valid_o = 1'b1;
        data_o  = DATA_WIDTH'(head.ruser);
`endif
        state_d = bus.ready ? BEAT : state_q;
      end
      BEAT: begin
        valid_o = !empty;
        if (!empty && !head.rresp[1]) data_o = head.rdata;
        if (!empty && head.rresp[1]) begin
          data_o[TOP -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
          data_o[RSP -: 2] = head.rresp;
        end
        if (!empty && bus.ready) begin
          pop     = 1'b1;
          beats_d = &beats_q ? beats_q : beats_q + 1'b1;
          worst_d = head.rresp > worst_q ? head.rresp : worst_q;
          state_d = head.rlast ? TRL : BEAT;
        end
      end
      TRL: begin
        valid_o = 1'b1;
        last_o  = 1'b1;
        data_o[TOP -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
        data_o[RSP -: 2] = worst_q;
        data_o[CNT_WIDTH-1:0] = beats_q;
        state_d = bus.ready ? IDLE : TRL;
      end
      default: state_d = IDLE;
    endcase
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      worst_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      worst_q <= worst_d;
    end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule
